// File: rtl/dds_pkg.sv
// Shared constants and encodings for the DDS frequency-sweep controller.
package dds_pkg;

    localparam int unsigned ACC_MODULUS = 200000;
    localparam int unsigned ADDR_SCALE  = 100;
    localparam int unsigned REF_HZ      = 1000;
    localparam int unsigned F_MIN       = 50;
    localparam int unsigned F_MAX       = 25000;
    // Phase-step units per Hz follow from the accumulator geometry.
    localparam int unsigned STEP_PER_HZ = ACC_MODULUS / ADDR_SCALE / REF_HZ;

    typedef enum logic [1:0] {
        MODE_ONCE     = 2'd0,
        MODE_REPEAT   = 2'd1,
        MODE_TRIANGLE = 2'd2,
        MODE_ONCE_ALT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/dds_sweep_next.sv
// Next sweep point: step toward the segment end, clamp at it, and flag arrival.
// When turning is enabled and the end is reached, steps back toward the segment begin.
module dds_sweep_next #(
    parameter int unsigned FREQ_W = 16
) (
    input  logic [FREQ_W-1:0] cur,
    input  logic [FREQ_W-1:0] inc,
    input  logic [FREQ_W-1:0] seg_begin,
    input  logic [FREQ_W-1:0] seg_end,
    input  logic              up,
    input  logic              turn_en,
    output logic [FREQ_W-1:0] nxt_c,
    output logic              reached_c
);

    logic              turn;
    logic              dir_up;
    logic [FREQ_W-1:0] end_pt;
    logic [FREQ_W:0]   sum;
    logic [FREQ_W:0]   diff;

    always_comb begin
        reached_c = (cur == seg_end);
        turn      = reached_c && turn_en;
        dir_up    = up ^ turn;
        end_pt    = turn ? seg_begin : seg_end;
        sum       = {1'b0, cur} + {1'b0, inc};
        diff      = {1'b0, cur} - {1'b0, inc};
        nxt_c     = end_pt;
        // Extra bit catches both carry-out and borrow before the endpoint clamp.
        if (dir_up) begin
            if (sum <= {1'b0, end_pt}) begin
                nxt_c = sum[FREQ_W-1:0];
            end
        end else begin
            if (!diff[FREQ_W] && (diff >= {1'b0, end_pt})) begin
                nxt_c = diff[FREQ_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler: steps the DDS output frequency between two endpoints,
// holding each point for a programmable dwell, with pause, abort and three sweep modes.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned FREQ_W  = 16,
    parameter int unsigned DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               hold_toggle,
    input  logic [1:0]         mode,
    input  logic [FREQ_W-1:0]  f_start,
    input  logic [FREQ_W-1:0]  f_stop,
    input  logic [FREQ_W-1:0]  f_inc,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FREQ_W-1:0]  freq_out,
    output logic [FREQ_W-1:0]  phase_step,
    output logic               step_load,
    output logic               busy,
    output logic               holding,
    output logic               done,
    output logic               cfg_err
);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic [FREQ_W-1:0]  phase_q, phase_d;
    logic [FREQ_W-1:0]  inc_q, inc_d;
    logic [FREQ_W-1:0]  seg_begin_q, seg_begin_d;
    logic [FREQ_W-1:0]  seg_end_q, seg_end_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               up_q, up_d;
    logic               step_load_q, step_load_d;
    logic               busy_q, busy_d;
    logic               holding_q, holding_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;

    logic [FREQ_W-1:0]  fs_c;
    logic [FREQ_W-1:0]  fe_c;
    logic [FREQ_W-1:0]  nxt_c;
    logic               reached_c;

    function automatic logic [FREQ_W-1:0] clamp_freq(input logic [FREQ_W-1:0] f);
        if (f < FREQ_W'(F_MIN)) return FREQ_W'(F_MIN);
        if (f > FREQ_W'(F_MAX)) return FREQ_W'(F_MAX);
        return f;
    endfunction

    dds_sweep_next #(
        .FREQ_W (FREQ_W)
    ) u_next (
        .cur       (freq_q),
        .inc       (inc_q),
        .seg_begin (seg_begin_q),
        .seg_end   (seg_end_q),
        .up        (up_q),
        .turn_en   (mode_q == MODE_TRIANGLE),
        .nxt_c     (nxt_c),
        .reached_c (reached_c)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        freq_d      = freq_q;
        inc_d       = inc_q;
        seg_begin_d = seg_begin_q;
        seg_end_d   = seg_end_q;
        dwell_d     = dwell_q;
        cnt_d       = cnt_q;
        up_d        = up_q;
        step_load_d = 1'b0;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        fs_c        = clamp_freq(f_start);
        fe_c        = clamp_freq(f_stop);

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (f_inc == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        mode_d      = mode_e'(mode);
                        up_d        = (fs_c <= fe_c);
                        inc_d       = f_inc;
                        seg_begin_d = fs_c;
                        seg_end_d   = fe_c;
                        dwell_d     = (dwell == '0) ? DWELL_W'(1) : dwell;
                        freq_d      = fs_c;
                        step_load_d = 1'b1;
                        cnt_d       = dwell_d - DWELL_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (hold_toggle) begin
                    state_d = ST_HOLD;
                    if (cnt_q != '0) cnt_d = cnt_q - DWELL_W'(1);
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (!reached_c) begin
                    freq_d      = nxt_c;
                    step_load_d = 1'b1;
                    cnt_d       = dwell_q - DWELL_W'(1);
                end else begin
                    // Endpoint has served its full dwell.
                    case (mode_q)
                        MODE_REPEAT: begin
                            freq_d      = seg_begin_q;
                            step_load_d = 1'b1;
                            cnt_d       = dwell_q - DWELL_W'(1);
                        end
                        MODE_TRIANGLE: begin
                            up_d        = ~up_q;
                            seg_begin_d = seg_end_q;
                            seg_end_d   = seg_begin_q;
                            freq_d      = nxt_c;
                            step_load_d = 1'b1;
                            cnt_d       = dwell_q - DWELL_W'(1);
                        end
                        default: begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (hold_toggle) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d    = (state_d != ST_IDLE);
        holding_d = (state_d == ST_HOLD);
        phase_d   = FREQ_W'(freq_d * STEP_PER_HZ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ONCE;
            freq_q      <= FREQ_W'(F_MIN);
            phase_q     <= FREQ_W'(F_MIN * STEP_PER_HZ);
            inc_q       <= '0;
            seg_begin_q <= '0;
            seg_end_q   <= '0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            up_q        <= 1'b0;
            step_load_q <= 1'b0;
            busy_q      <= 1'b0;
            holding_q   <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            freq_q      <= freq_d;
            phase_q     <= phase_d;
            inc_q       <= inc_d;
            seg_begin_q <= seg_begin_d;
            seg_end_q   <= seg_end_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            up_q        <= up_d;
            step_load_q <= step_load_d;
            busy_q      <= busy_d;
            holding_q   <= holding_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign freq_out   = freq_q;
    assign phase_step = phase_q;
    assign step_load  = step_load_q;
    assign busy       = busy_q;
    assign holding    = holding_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed scenarios plus random pulses, every cycle compared
// against a model that plays a precomputed list of sweep points.
module tb_dds_sweep_ctrl;

    localparam int unsigned FREQ_W  = 16;
    localparam int unsigned DWELL_W = 24;

    logic               clk;
    logic               rst;
    logic               start;
    logic               stop;
    logic               hold_toggle;
    logic [1:0]         mode;
    logic [FREQ_W-1:0]  f_start;
    logic [FREQ_W-1:0]  f_stop;
    logic [FREQ_W-1:0]  f_inc;
    logic [DWELL_W-1:0] dwell;
    logic [FREQ_W-1:0]  freq_out;
    logic [FREQ_W-1:0]  phase_step;
    logic               step_load;
    logic               busy;
    logic               holding;
    logic               done;
    logic               cfg_err;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    bit m_busy  = 0;
    bit m_hold  = 0;
    bit m_sl    = 0;
    bit m_done  = 0;
    bit m_cerr  = 0;
    bit m_once  = 0;
    bit m_tri   = 0;
    bit m_back  = 0;
    int m_freq  = 50;
    int m_left  = 0;
    int m_dwell = 1;
    int m_s     = 0;
    int m_e     = 0;
    int m_inc   = 0;
    int m_q[$];

    dds_sweep_ctrl #(
        .FREQ_W  (FREQ_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .hold_toggle (hold_toggle),
        .mode        (mode),
        .f_start     (f_start),
        .f_stop      (f_stop),
        .f_inc       (f_inc),
        .dwell       (dwell),
        .freq_out    (freq_out),
        .phase_step  (phase_step),
        .step_load   (step_load),
        .busy        (busy),
        .holding     (holding),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampf(input int f);
        if (f < 50) return 50;
        if (f > 25000) return 25000;
        return f;
    endfunction

    // Points visited walking from 'from' to 'to' (excluding 'from', ending on 'to').
    function automatic void add_pass(input int from, input int to);
        int cur;
        bit up;
        cur = from;
        up  = (to >= from);
        do begin
            if (up) cur = (cur + m_inc > to) ? to : cur + m_inc;
            else    cur = (cur - m_inc < to) ? to : cur - m_inc;
            m_q.push_back(cur);
        end while (cur != to);
    endfunction

    function automatic void load_next();
        m_freq = m_q.pop_front();
        m_left = m_dwell;
        m_sl   = 1;
    endfunction

    function automatic void model_step(input bit i_start, input bit i_stop,
                                       input bit i_tog, input bit i_rst);
        m_sl   = 0;
        m_done = 0;
        m_cerr = 0;
        if (i_rst) begin
            m_busy = 0;
            m_hold = 0;
            m_freq = 50;
            m_q.delete();
        end else if (!m_busy) begin
            if (i_start && !i_stop) begin
                if (int'(f_inc) == 0) begin
                    m_cerr = 1;
                end else begin
                    m_s     = clampf(int'(f_start));
                    m_e     = clampf(int'(f_stop));
                    m_inc   = int'(f_inc);
                    m_dwell = (int'(dwell) == 0) ? 1 : int'(dwell);
                    m_once  = (mode == 2'd0) || (mode == 2'd3);
                    m_tri   = (mode == 2'd2);
                    m_back  = 1;
                    m_q.delete();
                    m_q.push_back(m_s);
                    if (m_s != m_e) add_pass(m_s, m_e);
                    load_next();
                    m_busy = 1;
                    m_hold = 0;
                end
            end
        end else if (i_stop) begin
            m_busy = 0;
            m_hold = 0;
        end else if (m_hold) begin
            if (i_tog) m_hold = 0;
        end else if (i_tog) begin
            m_hold = 1;
            if (m_left > 1) m_left--;
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_q.size() == 0) begin
                    if (m_once) begin
                        m_busy = 0;
                        m_done = 1;
                    end else if (m_tri) begin
                        if (m_back) add_pass(m_e, m_s);
                        else        add_pass(m_s, m_e);
                        m_back = !m_back;
                    end else begin
                        m_q.push_back(m_s);
                        if (m_s != m_e) add_pass(m_s, m_e);
                    end
                end
                if (m_busy) load_next();
            end
        end
    endfunction

    task automatic compare_all();
        chk("freq_out",   int'(freq_out),   m_freq);
        chk("phase_step", int'(phase_step), m_freq * 2);
        chk("step_load",  int'(step_load),  int'(m_sl));
        chk("busy",       int'(busy),       int'(m_busy));
        chk("holding",    int'(holding),    int'(m_hold));
        chk("done",       int'(done),       int'(m_done));
        chk("cfg_err",    int'(cfg_err),    int'(m_cerr));
    endtask

    task automatic tick(input bit i_start, input bit i_stop, input bit i_tog, input bit i_rst);
        start       = i_start;
        stop        = i_stop;
        hold_toggle = i_tog;
        rst         = i_rst;
        @(posedge clk);
        model_step(i_start, i_stop, i_tog, i_rst);
        #1;
        compare_all();
        start       = 1'b0;
        stop        = 1'b0;
        hold_toggle = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick(0, 0, 0, 0);
    endtask

    task automatic set_cfg(input int fs, input int fe, input int inc, input int dw, input int md);
        f_start = 16'(fs);
        f_stop  = 16'(fe);
        f_inc   = 16'(inc);
        dwell   = 24'(dw);
        mode    = 2'(md);
    endtask

    initial begin
        int fs, fe, span;
        start = 1'b0; stop = 1'b0; hold_toggle = 1'b0; rst = 1'b0;
        set_cfg(1000, 1300, 100, 4, 0);

        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        chk("rst_freq", int'(freq_out), 50);
        chk("rst_phase", int'(phase_step), 100);

        // Once mode: points every 4 cycles, done 4 cycles after the last point
        tick(1, 0, 0, 0);
        chk("once_first", int'(freq_out), 1000);
        run(16);
        chk("once_done", int'(done), 1);
        chk("once_idle", int'(busy), 0);
        chk("once_keep", int'(freq_out), 1300);
        run(3);

        // Clamped start and overshooting final step
        set_cfg(10, 30000, 20000, 2, 0);
        tick(1, 0, 0, 0);
        chk("clamp_start", int'(freq_out), 50);
        run(4);
        chk("clamp_top_phase", int'(phase_step), 50000);
        run(4);

        // Triangle, dwell 1, then abort
        set_cfg(100, 300, 100, 1, 2);
        tick(1, 0, 0, 0);
        run(12);
        tick(0, 1, 0, 0);
        chk("tri_stop_busy", int'(busy), 0);
        run(2);

        // Repeat mode with a 10-cycle pause mid-dwell
        set_cfg(500, 800, 100, 8, 1);
        tick(1, 0, 0, 0);
        run(3);
        tick(0, 0, 1, 0);
        run(9);
        tick(0, 0, 1, 0);
        run(40);
        tick(0, 1, 0, 0);

        // Rejected config, ignored restart, stop beating start
        set_cfg(500, 800, 0, 3, 0);
        tick(1, 0, 0, 0);
        chk("inc0_err", int'(cfg_err), 1);
        set_cfg(500, 800, 100, 3, 0);
        tick(1, 0, 0, 0);
        run(2);
        f_start = 16'd2000;
        tick(1, 0, 0, 0);
        run(3);
        tick(1, 1, 0, 0);
        chk("start_stop_idle", int'(busy), 0);
        run(2);

        // Reset while holding
        set_cfg(2000, 3000, 250, 5, 1);
        tick(1, 0, 0, 0);
        run(2);
        tick(0, 0, 1, 0);
        run(3);
        tick(0, 0, 0, 1);
        chk("rst_hold_freq", int'(freq_out), 50);
        chk("rst_hold_holding", int'(holding), 0);
        run(2);

        // Random pulses and configurations
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                fs   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 100))
                                                   : int'($urandom_range(0, 26000));
                span = int'($urandom_range(0, 3000));
                fe   = ($urandom_range(0, 1) == 1) ? fs + span : fs - span;
                if (fe < 0) fe = 0;
                set_cfg(fs, fe,
                        ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 1500)),
                        int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
            end
            tick($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 399) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
